fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter XLEN, default 32, instruction and address width.
REQ-002 Parameter DEPTH, default 4, queue entries; power of two, at least 2.
REQ-003 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset, with ports exactly as follows:
  clk  in  1  sole clock, rising edge
  reset  in  1  synchronous, active-high reset
  imem_addr  out  XLEN  fetch PC presented to instruction memory
  imem_rdata  in  XLEN  instruction at imem_addr, same cycle (combinational memory)
  redirect  in  1  branch-taken, J/JAL or JR resolved in decode
  redirect_pc  in  XLEN  target PC, valid when redirect=1
  stall_d  in  1  decode stage stalled (load-use or branch hazard)
  valid_d  out  1  instr_d/pcplus4_d hold a real instruction
  instr_d  out  XLEN  head instruction for decode
  pcplus4_d  out  XLEN  fetch PC of head plus 4
  count  out  $clog2(DEPTH)+1  current occupancy

Function
REQ-005 Fetch: the block SHALL fetch, storing {imem_rdata, imem_addr+4} at the tail and advancing PC by 4, when (count<DEPTH or pop this cycle) and redirect=0.
REQ-006 Pop: the block SHALL pop when valid_d=1 and stall_d=0; the head then advances on the next edge.
REQ-007 valid_d SHALL equal (count!=0); when valid_d=0, instr_d SHALL be 0 (a NOP bubble).
REQ-008 Full with simultaneous pop: a fetch SHALL occur and count SHALL be unchanged.
REQ-009 Empty with fetch and no bypass: the entry SHALL appear on instr_d one cycle after fetch.
REQ-010 Redirect SHALL have priority over stall_d and fetch: all entries are discarded, count becomes 0, PC becomes redirect_pc, and no push occurs that cycle.
REQ-011 After redirect: imem_addr SHALL be redirect_pc in the next cycle, and valid_d SHALL be 0 that cycle.
REQ-012 Pointers SHALL wrap modulo DEPTH.
REQ-013 count SHALL increment, decrement or hold per push/pop and never exceed DEPTH.
REQ-014 PC arithmetic SHALL be modulo 2^XLEN; 32'hFFFF_FFFC+4 wraps to 0.

Reset
REQ-015 While reset=1: PC=RESET_PC, count=0, pointers=0, valid_d=0, instr_d=0, and no fetch is stored.
REQ-016 Reset SHALL override redirect and stall_d.
REQ-017 Reset asserted mid-operation SHALL discard all entries on that edge.
REQ-018 The first fetch SHALL occur in the first cycle after reset deasserts, with imem_addr=RESET_PC.

Configuration
REQ-019 Macro FETCHQ_BYPASS_EN defined: when count=0, redirect=0 and a fetch occurs, the block SHALL drive valid_d=1 with instr_d=imem_rdata and pcplus4_d=imem_addr+4 combinationally.
  - If stall_d=0, the word is consumed and not written; count stays 0.
  - If stall_d=1, the word is written normally.
REQ-020 Macro FETCHQ_BYPASS_EN undefined: no bypass path exists, and behaviour follows REQ-009.

Structure
REQ-021 Package mips_pkg SHALL hold the XLEN default, the RESET_PC default and the NOP encoding constant (32'h0).
REQ-022 Storage SHALL be one sub-module, fetchq_ring: a DEPTH x 2*XLEN register array with write port and head read port, and no reset on data.
REQ-023 The PC register, the pointers, count and the bypass logic SHALL reside in fetch_queue.

Verification
REQ-024 Reset, then 6 cycles with stall_d=0 and no bypass: imem_addr = 0,4,8,...; valid_d rises in cycle 2; instr_d follows memory order with pcplus4_d=4,8,...
REQ-025 stall_d=1 held for 8 cycles, DEPTH=4: count saturates at 4; imem_addr stops advancing at 16; after release, 4 pops occur in order and fetch resumes at 16.
REQ-026 Queue full and stall_d=0: count stays 4, one push and one pop per cycle, and pointers wrap with no loss across 10 cycles.
REQ-027 redirect=1, redirect_pc=32'h40 while stall_d=1 and count=3: next cycle count=0, valid_d=0, imem_addr=32'h40; the cycle after, instr_d=mem[0x40].
REQ-028 reset asserted with count=2 and redirect=1 in the same cycle: next cycle imem_addr=RESET_PC and count=0.
REQ-029 FETCHQ_BYPASS_EN defined, after redirect to 32'h80 with stall_d=0: in the same cycle imem_addr=32'h80 and valid_d=1, instr_d=mem[0x80], pcplus4_d=32'h84, count=0.

Source files
------------

// File: rtl/mips_pkg.sv
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared constants for the MIPS fetch path: default datapath
//                width, default reset PC and the NOP (bubble) encoding.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package mips_pkg;

   localparam int unsigned C_XLEN     = 32;
   localparam logic [31:0] C_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] C_NOP      = 32'h0000_0000;

endpackage : mips_pkg

`default_nettype wire

// File: rtl/fetchq_ring.sv
// ============================================================================
//  Module      : fetchq_ring
//  Description : DEPTH x WIDTH register array backing the fetch queue.
//                One synchronous write port, one combinational read port.
//                Data storage is deliberately not reset; validity is tracked
//                by the occupancy count in the parent.
//  Ports       : clk     - rising-edge clock
//                i_we    - write enable
//                i_waddr - write slot (tail pointer)
//                i_wdata - entry to store
//                i_raddr - read slot (head pointer)
//                o_rdata - entry at i_raddr
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetchq_ring #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic [AW-1:0]    i_raddr,
   output logic [WIDTH-1:0] o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule : fetchq_ring

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
//  Module      : fetch_queue
//  Description : Instruction fetch stage with a small decoupling queue.
//                Fetches from a combinational instruction memory, buffers
//                {instr, pc+4} pairs and presents the head to decode.
//                Decode redirects flush the queue and reload the PC.
//  Config      : FETCHQ_BYPASS_EN - when defined, an empty queue forwards the
//                word being fetched straight to decode in the same cycle.
//  Ports       : clk, reset     - clock, synchronous active-high reset
//                imem_addr      - fetch PC to instruction memory
//                imem_rdata     - instruction at imem_addr (same cycle)
//                redirect       - flush and reload PC from redirect_pc
//                redirect_pc    - new fetch PC
//                stall_d        - decode stalled, head is not consumed
//                valid_d        - instr_d/pcplus4_d are a real instruction
//                instr_d        - head instruction (NOP when not valid)
//                pcplus4_d      - head fetch PC plus 4
//                count          - current occupancy
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_queue
   import mips_pkg::*;
#(
   parameter int              XLEN     = C_XLEN,
   parameter int              DEPTH    = 4,   // power of two, >= 2
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(C_RESET_PC)
) (
   input  logic                     clk,
   input  logic                     reset,
   output logic [XLEN-1:0]          imem_addr,
   input  logic [XLEN-1:0]          imem_rdata,
   input  logic                     redirect,
   input  logic [XLEN-1:0]          redirect_pc,
   input  logic                     stall_d,
   output logic                     valid_d,
   output logic [XLEN-1:0]          instr_d,
   output logic [XLEN-1:0]          pcplus4_d,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0]   C_DEPTH = CW'(DEPTH);
   localparam logic [XLEN-1:0] C_NOPX  = XLEN'(C_NOP);

   logic [XLEN-1:0]   r_pc;
   logic [AW-1:0]     r_head;
   logic [AW-1:0]     r_tail;
   logic [CW-1:0]     r_count;

   logic              w_not_empty;
   logic              w_qpop;
   logic              w_fetch;
   logic              w_push;
   logic              w_byp;
   logic [XLEN-1:0]   w_pc4;
   logic [2*XLEN-1:0] w_head_entry;

   assign w_pc4       = r_pc + XLEN'(4);
   assign w_not_empty = (r_count != '0);

   // A stored entry leaves whenever decode is not stalled.
   assign w_qpop  = w_not_empty && !stall_d;

   // A slot freed by this cycle's pop can be refilled in the same cycle,
   // so a full queue keeps streaming at one instruction per cycle.
   assign w_fetch = !reset && !redirect && ((r_count < C_DEPTH) || w_qpop);

`ifdef FETCHQ_BYPASS_EN
   // Empty queue: the fetched word is shown to decode directly. If decode
   // takes it this cycle there is no need to store it.
   assign w_byp  = w_fetch && !w_not_empty;
   assign w_push = w_fetch && !(w_byp && !stall_d);
`else
   assign w_byp  = 1'b0;
   assign w_push = w_fetch;
`endif

   fetchq_ring #(
      .DEPTH (DEPTH),
      .WIDTH (2*XLEN),
      .AW    (AW)
   ) u_ring (
      .clk     (clk),
      .i_we    (w_push),
      .i_waddr (r_tail),
      .i_wdata ({imem_rdata, w_pc4}),
      .i_raddr (r_head),
      .o_rdata (w_head_entry)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc    <= RESET_PC;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (redirect) begin
         // Flush wins over any pending pop or push.
         r_pc    <= redirect_pc;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_fetch) begin
            r_pc <= w_pc4;
         end
         // Pointers are AW bits wide, so increment wraps modulo DEPTH.
         if (w_push) begin
            r_tail <= r_tail + AW'(1);
         end
         if (w_qpop) begin
            r_head <= r_head + AW'(1);
         end
         case ({w_push, w_qpop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign imem_addr = r_pc;
   assign count     = r_count;
   assign valid_d   = !reset && (w_not_empty || w_byp);

   always_comb begin
      instr_d   = C_NOPX;
      pcplus4_d = '0;
      if (!reset) begin
         if (w_not_empty) begin
            instr_d   = w_head_entry[2*XLEN-1:XLEN];
            pcplus4_d = w_head_entry[XLEN-1:0];
         end else if (w_byp) begin
            instr_d   = imem_rdata;
            pcplus4_d = w_pc4;
         end
      end
   end

endmodule : fetch_queue

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// ============================================================================
//  Module      : tb_fetch_queue
//  Description : Self-checking bench for fetch_queue. A queue-based reference
//                model tracks the expected contents and fetch PC; directed
//                scenarios plus a randomized run compare DUT outputs to it.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_queue;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        stall_d;
   logic        valid_d;
   logic [31:0] instr_d;
   logic [31:0] pcplus4_d;
   logic [2:0]  count;

   int vectors    = 0;
   int miscompares = 0;

   // reference model state and expected outputs
   logic [63:0] mq[$];
   logic [31:0] mpc;
   logic        m_valid;
   logic [31:0] m_instr;
   logic [31:0] m_pc4;
   logic [2:0]  m_count;

   always #5 clk = ~clk;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
   endfunction

   assign imem_rdata = memf(imem_addr);

   fetch_queue #(
      .XLEN     (32),
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .stall_d     (stall_d),
      .valid_d     (valid_d),
      .instr_d     (instr_d),
      .pcplus4_d   (pcplus4_d),
      .count       (count)
   );

   // Apply inputs away from the edge, then compute what decode should see.
   task automatic drive(input logic r, input logic s, input logic rd,
                        input logic [31:0] rpc);
      logic byp;
      @(negedge clk);
      reset = r; stall_d = s; redirect = rd; redirect_pc = rpc;
      #1;
      byp = 1'b0;
`ifdef FETCHQ_BYPASS_EN
      byp = !r && !rd && (mq.size() == 0);
`endif
      m_count = 3'(mq.size());
      m_valid = 1'b0; m_instr = 32'h0; m_pc4 = 32'h0;
      if (!r) begin
         if (mq.size() != 0) begin
            m_valid = 1'b1; m_instr = mq[0][63:32]; m_pc4 = mq[0][31:0];
         end else if (byp) begin
            m_valid = 1'b1; m_instr = memf(mpc); m_pc4 = mpc + 32'd4;
         end
      end
   endtask

   // Advance the model across one rising edge using the applied inputs.
   task automatic step();
      logic pop, fetch, keep;
      @(posedge clk);
      if (reset) begin
         mq.delete(); mpc = RESET_PC;
      end else if (redirect) begin
         mq.delete(); mpc = redirect_pc;
      end else begin
         pop   = (mq.size() > 0) && !stall_d;
         fetch = (mq.size() < DEPTH) || pop;
         keep  = 1'b1;
`ifdef FETCHQ_BYPASS_EN
         if (mq.size() == 0 && !stall_d) keep = 1'b0;
`endif
         if (pop) void'(mq.pop_front());
         if (fetch) begin
            if (keep) mq.push_back({memf(mpc), mpc + 32'd4});
            mpc = mpc + 32'd4;
         end
      end
   endtask

   task automatic test_reset();
      drive(1, 0, 0, 0); step();
      drive(1, 1, 1, 32'h100);
      vectors++;
      if ({valid_d, instr_d, count, imem_addr} !== {1'b0, 32'h0, 3'd0, RESET_PC}) begin
         miscompares++;
         $display("FAIL reset: got v=%b i=%h c=%0d a=%h want v=0 i=0 c=0 a=%h",
                  valid_d, instr_d, count, imem_addr, RESET_PC);
      end
      step();
   endtask

   task automatic test_stream();
      drive(1, 0, 0, 0); step();
      for (int i = 0; i < 6; i++) begin
         drive(0, 0, 0, 0);
         vectors++;
         if ({valid_d, instr_d, pcplus4_d, count, imem_addr} !==
             {m_valid, m_instr, m_pc4, m_count, mpc} || imem_addr !== 32'(4*i)) begin
            miscompares++;
            $display("FAIL stream[%0d]: got v=%b i=%h p=%h c=%0d a=%h want v=%b i=%h p=%h c=%0d a=%h",
                     i, valid_d, instr_d, pcplus4_d, count, imem_addr,
                     m_valid, m_instr, m_pc4, m_count, 32'(4*i));
         end
         step();
      end
   endtask

   task automatic test_stall();
      drive(1, 0, 0, 0); step();
      for (int i = 0; i < 8; i++) begin drive(0, 1, 0, 0); step(); end
      drive(0, 1, 0, 0);
      vectors++;
      if (count !== 3'd4 || imem_addr !== 32'd16) begin
         miscompares++;
         $display("FAIL stall_sat: got c=%0d a=%h want c=4 a=00000010", count, imem_addr);
      end
      step();
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 0, 0);
         vectors++;
         if (instr_d !== memf(32'(4*i)) || pcplus4_d !== 32'(4*i+4) || valid_d !== 1'b1
             || imem_addr !== 32'(16+4*i)) begin
            miscompares++;
            $display("FAIL stall_drain[%0d]: got v=%b i=%h p=%h a=%h want v=1 i=%h p=%h a=%h",
                     i, valid_d, instr_d, pcplus4_d, imem_addr,
                     memf(32'(4*i)), 32'(4*i+4), 32'(16+4*i));
         end
         step();
      end
   endtask

   task automatic test_full_stream();
      drive(1, 0, 0, 0); step();
      for (int i = 0; i < 4; i++) begin drive(0, 1, 0, 0); step(); end
      for (int i = 0; i < 10; i++) begin
         drive(0, 0, 0, 0);
         vectors++;
         if (count !== 3'd4 || instr_d !== memf(32'(4*i)) ||
             {valid_d, pcplus4_d, imem_addr} !== {m_valid, m_pc4, mpc}) begin
            miscompares++;
            $display("FAIL full_stream[%0d]: got c=%0d i=%h p=%h a=%h want c=4 i=%h p=%h a=%h",
                     i, count, instr_d, pcplus4_d, imem_addr, memf(32'(4*i)), m_pc4, mpc);
         end
         step();
      end
   endtask

   task automatic test_redirect();
      drive(1, 0, 0, 0); step();
      for (int i = 0; i < 3; i++) begin drive(0, 1, 0, 0); step(); end
      drive(0, 1, 1, 32'h40);
      vectors++;
      if (count !== 3'd3) begin
         miscompares++;
         $display("FAIL redir_pre: got c=%0d want c=3", count);
      end
      step();
      drive(0, 1, 0, 0);
      vectors++;
      if (count !== 3'd0 || imem_addr !== 32'h40
`ifndef FETCHQ_BYPASS_EN
          || valid_d !== 1'b0
`endif
         ) begin
         miscompares++;
         $display("FAIL redir_next: got c=%0d a=%h v=%b want c=0 a=00000040",
                  count, imem_addr, valid_d);
      end
      step();
      drive(0, 1, 0, 0);
      vectors++;
      if (instr_d !== memf(32'h40) || pcplus4_d !== 32'h44 || valid_d !== 1'b1) begin
         miscompares++;
         $display("FAIL redir_data: got v=%b i=%h p=%h want v=1 i=%h p=00000044",
                  valid_d, instr_d, pcplus4_d, memf(32'h40));
      end
      step();
   endtask

   task automatic test_reset_redirect();
      drive(1, 0, 0, 0); step();
      for (int i = 0; i < 2; i++) begin drive(0, 1, 0, 0); step(); end
      drive(1, 1, 1, 32'h200);
      vectors++;
      if (valid_d !== 1'b0 || instr_d !== 32'h0) begin
         miscompares++;
         $display("FAIL rst_redir_during: got v=%b i=%h want v=0 i=0", valid_d, instr_d);
      end
      step();
      drive(0, 0, 0, 0);
      vectors++;
      if (imem_addr !== RESET_PC || count !== 3'd0) begin
         miscompares++;
         $display("FAIL rst_redir_after: got a=%h c=%0d want a=%h c=0", imem_addr, count, RESET_PC);
      end
      step();
   endtask

   task automatic test_pc_wrap();
      logic [31:0] want;
      drive(0, 1, 1, 32'hFFFF_FFF8); step();
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 0, 0);
         want = 32'hFFFF_FFF8 + 32'(4*i);
         vectors++;
         if (imem_addr !== want) begin
            miscompares++;
            $display("FAIL pc_wrap[%0d]: got a=%h want a=%h", i, imem_addr, want);
         end
         step();
      end
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 0, 0);
         vectors++;
         if ({valid_d, instr_d, pcplus4_d, count, imem_addr} !==
             {m_valid, m_instr, m_pc4, m_count, mpc}) begin
            miscompares++;
            $display("FAIL pc_wrap_drain[%0d]: got v=%b i=%h p=%h c=%0d a=%h want v=%b i=%h p=%h c=%0d a=%h",
                     i, valid_d, instr_d, pcplus4_d, count, imem_addr,
                     m_valid, m_instr, m_pc4, m_count, mpc);
         end
         step();
      end
   endtask

`ifdef FETCHQ_BYPASS_EN
   task automatic test_bypass();
      drive(0, 0, 1, 32'h80); step();
      drive(0, 0, 0, 0);
      vectors++;
      if ({valid_d, instr_d, pcplus4_d, count, imem_addr} !==
          {1'b1, memf(32'h80), 32'h84, 3'd0, 32'h80}) begin
         miscompares++;
         $display("FAIL bypass: got v=%b i=%h p=%h c=%0d a=%h want v=1 i=%h p=00000084 c=0 a=00000080",
                  valid_d, instr_d, pcplus4_d, count, imem_addr, memf(32'h80));
      end
      step();
   endtask
`endif

   task automatic test_random();
      logic r, s, rd;
      logic [31:0] rpc;
      for (int i = 0; i < 400; i++) begin
         r   = ($urandom_range(0, 99) < 2);
         s   = ($urandom_range(0, 99) < 45);
         rd  = ($urandom_range(0, 99) < 6);
         rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom() & 32'h0000_FFFC);
         drive(r, s, rd, rpc);
         vectors++;
         if ({valid_d, instr_d, pcplus4_d, count, imem_addr} !==
             {m_valid, m_instr, m_pc4, m_count, mpc}) begin
            miscompares++;
            $display("FAIL random[%0d]: got v=%b i=%h p=%h c=%0d a=%h want v=%b i=%h p=%h c=%0d a=%h",
                     i, valid_d, instr_d, pcplus4_d, count, imem_addr,
                     m_valid, m_instr, m_pc4, m_count, mpc);
         end
         step();
      end
   endtask

   initial begin
      reset = 1'b1; stall_d = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
      mpc = RESET_PC;
      test_reset();
      test_stream();
      test_stall();
      test_full_stream();
      test_redirect();
      test_reset_redirect();
      test_pc_wrap();
`ifdef FETCHQ_BYPASS_EN
      test_bypass();
`endif
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_fetch_queue

`default_nettype wire
